// File: rtl/fwd_tracker.sv
// fwd_tracker: tracks in-flight register producers behind decode and resolves
// operand forwarding and hazard stalls for each decode read port.
//
// Each tracked stage carries {vld, waddr, tnew}. The record shifts one stage
// per clock, and its tnew counts down toward 0, where the result exists.
// Operand selection and the stall request are purely combinational.
//
// Optional build macro: FWD_TRACKER_STAT_EN adds the stat_stall / stat_fwd
// cycle counters and their output ports.

module fwd_tracker #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NSTG = 3,
    parameter int NRP  = 2,
    parameter int TW   = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic                iss_valid,
    input  logic                iss_we,
    input  logic [AW-1:0]       iss_waddr,
    input  logic [TW-1:0]       iss_tnew,
    input  logic [NSTG*DW-1:0]  stg_data,
    input  logic [NRP*AW-1:0]   rd_addr,
    input  logic [NRP*TW-1:0]   rd_tuse,
    input  logic [NRP*DW-1:0]   rf_data,
    output logic [NRP*DW-1:0]   rd_data,
    output logic [NRP-1:0]      rd_fwd,
    output logic                stall_o
`ifdef FWD_TRACKER_STAT_EN
    ,
    output logic [31:0]         stat_stall,
    output logic [31:0]         stat_fwd
`endif
);

    logic [NSTG-1:0] vld_q, vld_d;
    logic [AW-1:0]   waddr_q [NSTG];
    logic [AW-1:0]   waddr_d [NSTG];
    logic [TW-1:0]   tnew_q  [NSTG];
    logic [TW-1:0]   tnew_d  [NSTG];

    logic            issue_ok;

    logic [NRP-1:0]  hit;
    logic [TW-1:0]   win_tnew [NRP];
    logic [DW-1:0]   win_data [NRP];

    // An instruction is captured only if it writes a register and decode is not held.
    assign issue_ok = iss_valid & iss_we & ~stall_o & ~stall_i;

    // Next stage contents: load stage 0, shift the rest with saturating tnew decrement.
    always_comb begin
        vld_d      = '0;
        waddr_d[0] = iss_waddr;
        tnew_d[0]  = iss_tnew;
        vld_d[0]   = issue_ok;
        for (int k = 1; k < NSTG; k++) begin
            vld_d[k]   = vld_q[k-1];
            waddr_d[k] = waddr_q[k-1];
            tnew_d[k]  = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TW'(1);
        end
        // Flush overrides any concurrent issue.
        if (flush_i) begin
            vld_d = '0;
        end
    end

    // Stage register with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int k = 0; k < NSTG; k++) begin
                waddr_q[k] <= '0;
                tnew_q[k]  <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < NSTG; k++) begin
                waddr_q[k] <= waddr_d[k];
                tnew_q[k]  <= tnew_d[k];
            end
        end
    end

    // Per-port match search; scanning oldest to youngest lets the youngest win.
    always_comb begin
        hit = '0;
        for (int p = 0; p < NRP; p++) begin
            win_tnew[p] = '0;
            win_data[p] = '0;
            for (int k = NSTG - 1; k >= 0; k--) begin
                if (vld_q[k] && (waddr_q[k] == rd_addr[p*AW +: AW]) &&
                    (rd_addr[p*AW +: AW] != '0)) begin
                    hit[p]      = 1'b1;
                    win_tnew[p] = tnew_q[k];
                    win_data[p] = stg_data[k*DW +: DW];
                end
            end
        end
    end

    // Operand mux and stall request from the winning producer of each port.
    always_comb begin
        rd_data = rf_data;
        rd_fwd  = '0;
        stall_o = 1'b0;
        for (int p = 0; p < NRP; p++) begin
            if (hit[p] && (win_tnew[p] == '0)) begin
                rd_data[p*DW +: DW] = win_data[p];
                rd_fwd[p]           = 1'b1;
            end
            if (hit[p] && (win_tnew[p] > rd_tuse[p*TW +: TW])) begin
                stall_o = 1'b1;
            end
        end
    end

`ifdef FWD_TRACKER_STAT_EN
    logic [31:0] stat_stall_q, stat_stall_d;
    logic [31:0] stat_fwd_q,   stat_fwd_d;

    // Counter next values; flush restarts both counts, natural 32-bit wrap.
    always_comb begin
        stat_stall_d = stat_stall_q + 32'(stall_o);
        stat_fwd_d   = stat_fwd_q + 32'(|rd_fwd);
        if (flush_i) begin
            stat_stall_d = '0;
            stat_fwd_d   = '0;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_stall_q <= '0;
            stat_fwd_q   <= '0;
        end else begin
            stat_stall_q <= stat_stall_d;
            stat_fwd_q   <= stat_fwd_d;
        end
    end

    assign stat_stall = stat_stall_q;
    assign stat_fwd   = stat_fwd_q;
`endif

endmodule

// File: tb/tb_fwd_tracker.sv
// Directed testbench for fwd_tracker (default parameters).
// Build with FWD_TRACKER_STAT_EN defined to also exercise the statistics counters.

module tb_fwd_tracker;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NSTG = 3;
    localparam int NRP  = 2;
    localparam int TW   = 2;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                stall_i;
    logic                flush_i;
    logic                iss_valid;
    logic                iss_we;
    logic [AW-1:0]       iss_waddr;
    logic [TW-1:0]       iss_tnew;
    logic [NSTG*DW-1:0]  stg_data;
    logic [NRP*AW-1:0]   rd_addr;
    logic [NRP*TW-1:0]   rd_tuse;
    logic [NRP*DW-1:0]   rf_data;
    logic [NRP*DW-1:0]   rd_data;
    logic [NRP-1:0]      rd_fwd;
    logic                stall_o;
`ifdef FWD_TRACKER_STAT_EN
    logic [31:0]         stat_stall;
    logic [31:0]         stat_fwd;
`endif

    int errors = 0;
    int checks = 0;

    fwd_tracker #(.DW(DW), .AW(AW), .NSTG(NSTG), .NRP(NRP), .TW(TW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .stall_i   (stall_i),
        .flush_i   (flush_i),
        .iss_valid (iss_valid),
        .iss_we    (iss_we),
        .iss_waddr (iss_waddr),
        .iss_tnew  (iss_tnew),
        .stg_data  (stg_data),
        .rd_addr   (rd_addr),
        .rd_tuse   (rd_tuse),
        .rf_data   (rf_data),
        .rd_data   (rd_data),
        .rd_fwd    (rd_fwd),
        .stall_o   (stall_o)
`ifdef FWD_TRACKER_STAT_EN
        ,
        .stat_stall(stat_stall),
        .stat_fwd  (stat_fwd)
`endif
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a, input logic [TW-1:0] t,
                          input logic [DW-1:0] rf);
        rd_addr[p*AW +: AW] = a;
        rd_tuse[p*TW +: TW] = t;
        rf_data[p*DW +: DW] = rf;
    endtask

    task automatic set_stg(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                           input logic [DW-1:0] d2);
        stg_data = {d2, d1, d0};
    endtask

    function automatic logic [DW-1:0] dat(input int p);
        return rd_data[p*DW +: DW];
    endfunction

    task automatic clear_rd();
        rd_addr = '0;
        rd_tuse = '0;
    endtask

    // Present one writing instruction for one edge with no read ports active.
    task automatic issue(input logic [AW-1:0] a, input logic [TW-1:0] t);
        clear_rd();
        iss_valid = 1'b1; iss_we = 1'b1; iss_waddr = a; iss_tnew = t;
        cyc();
        iss_valid = 1'b0; iss_we = 1'b0;
    endtask

    task automatic clear_pipe();
        clear_rd();
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set_rd(0, 5'd3, 2'd0, 32'h1111_1111);
        set_rd(1, 5'd4, 2'd0, 32'h2222_2222);
        iss_valid = 1'b1; iss_we = 1'b1; iss_waddr = 5'd3; iss_tnew = 2'd0;
        cyc(); cyc();
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b exp 0", stall_o); end
        checks++; if (rd_fwd !== 2'b00) begin errors++; $display("FAIL rst_fwd: got %b exp 00", rd_fwd); end
        checks++; if (rd_data !== {32'h2222_2222, 32'h1111_1111}) begin errors++; $display("FAIL rst_data: got %h exp %h", rd_data, {32'h2222_2222, 32'h1111_1111}); end
        // Release mid-cycle with an issue pending; the next edge must accept it.
        clear_rd();
        reset_n = 1'b1;
        cyc();
        iss_valid = 1'b0; iss_we = 1'b0;
        set_rd(0, 5'd3, 2'd0, 32'h1111_1111);
        set_stg(32'hAAAA, 32'h0, 32'h0);
        #1;
        checks++; if (rd_fwd[0] !== 1'b1 || dat(0) !== 32'hAAAA) begin errors++; $display("FAIL rst_release_issue: got fwd=%b data=%h exp fwd=1 data=0000aaaa", rd_fwd[0], dat(0)); end
    endtask

    task automatic test_fwd_e();
        clear_pipe();
        issue(5'd8, 2'd0);
        set_rd(0, 5'd8, 2'd0, 32'hDEAD);
        set_rd(1, 5'd0, 2'd0, 32'hBEEF);
        set_stg(32'h1234, 32'h5555, 32'h6666);
        #1;
        checks++; if (dat(0) !== 32'h1234) begin errors++; $display("FAIL fwd_e_data: got %h exp 00001234", dat(0)); end
        checks++; if (rd_fwd !== 2'b01) begin errors++; $display("FAIL fwd_e_flag: got %b exp 01", rd_fwd); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL fwd_e_stall: got %b exp 0", stall_o); end
        cyc();
        checks++; if (dat(0) !== 32'h5555 || rd_fwd[0] !== 1'b1) begin errors++; $display("FAIL fwd_m: got %h/%b exp 00005555/1", dat(0), rd_fwd[0]); end
        cyc();
        checks++; if (dat(0) !== 32'h6666 || rd_fwd[0] !== 1'b1) begin errors++; $display("FAIL fwd_w: got %h/%b exp 00006666/1", dat(0), rd_fwd[0]); end
        cyc();
        checks++; if (dat(0) !== 32'hDEAD || rd_fwd[0] !== 1'b0) begin errors++; $display("FAIL fwd_retired: got %h/%b exp 0000dead/0", dat(0), rd_fwd[0]); end
    endtask

    task automatic test_load_use();
        clear_pipe();
        issue(5'd9, 2'd1);
        set_rd(1, 5'd9, 2'd0, 32'h77);
        set_stg(32'h99, 32'hBB, 32'h0);
        // A second instruction offered during the stall must be refused.
        iss_valid = 1'b1; iss_we = 1'b1; iss_waddr = 5'd12; iss_tnew = 2'd0;
        #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b exp 1", stall_o); end
        checks++; if (rd_fwd[1] !== 1'b0 || dat(1) !== 32'h77) begin errors++; $display("FAIL lu_rf: got %h/%b exp 00000077/0", dat(1), rd_fwd[1]); end
        cyc();
        iss_valid = 1'b0; iss_we = 1'b0;
        set_rd(0, 5'd12, 2'd0, 32'hC0);
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL lu_release: got %b exp 0", stall_o); end
        checks++; if (rd_fwd[1] !== 1'b1 || dat(1) !== 32'hBB) begin errors++; $display("FAIL lu_fwd_m: got %h/%b exp 000000bb/1", dat(1), rd_fwd[1]); end
        checks++; if (rd_fwd[0] !== 1'b0 || dat(0) !== 32'hC0) begin errors++; $display("FAIL lu_refused: got %h/%b exp 000000c0/0", dat(0), rd_fwd[0]); end
        // tnew equal to tuse is not a hazard.
        clear_pipe();
        issue(5'd9, 2'd1);
        set_rd(1, 5'd9, 2'd1, 32'h77);
        #1;
        checks++; if (stall_o !== 1'b0 || rd_fwd[1] !== 1'b0) begin errors++; $display("FAIL lu_tuse_eq: got stall=%b fwd=%b exp 0/0", stall_o, rd_fwd[1]); end
    endtask

    task automatic test_priority();
        clear_pipe();
        issue(5'd5, 2'd0);
        issue(5'd5, 2'd0);
        set_rd(0, 5'd5, 2'd0, 32'hF);
        set_stg(32'hA, 32'hB, 32'h0);
        #1;
        checks++; if (dat(0) !== 32'hA || rd_fwd[0] !== 1'b1) begin errors++; $display("FAIL prio_young: got %h/%b exp 0000000a/1", dat(0), rd_fwd[0]); end
        // Youngest producer not ready: no fallback to the older ready one.
        clear_pipe();
        issue(5'd6, 2'd0);
        issue(5'd6, 2'd2);
        set_rd(0, 5'd6, 2'd3, 32'h60);
        #1;
        checks++; if (rd_fwd[0] !== 1'b0 || dat(0) !== 32'h60 || stall_o !== 1'b0) begin errors++; $display("FAIL prio_notready: got %h/%b/%b exp 00000060/0/0", dat(0), rd_fwd[0], stall_o); end
        set_rd(0, 5'd6, 2'd1, 32'h60);
        #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL prio_stall: got %b exp 1", stall_o); end
        // Non-writing instruction is not tracked.
        clear_pipe();
        clear_rd();
        iss_valid = 1'b1; iss_we = 1'b0; iss_waddr = 5'd7; iss_tnew = 2'd0;
        cyc();
        iss_valid = 1'b0;
        set_rd(0, 5'd7, 2'd0, 32'h70);
        #1;
        checks++; if (rd_fwd[0] !== 1'b0 || dat(0) !== 32'h70) begin errors++; $display("FAIL no_we: got %h/%b exp 00000070/0", dat(0), rd_fwd[0]); end
    endtask

    task automatic test_reg_zero();
        clear_pipe();
        issue(5'd0, 2'd0);
        issue(5'd0, 2'd3);
        set_rd(0, 5'd0, 2'd0, 32'h0);
        set_rd(1, 5'd0, 2'd0, 32'h0);
        set_stg(32'h1, 32'h2, 32'h3);
        #1;
        checks++; if (rd_fwd !== 2'b00 || dat(0) !== 32'h0) begin errors++; $display("FAIL r0_fwd: got %h/%b exp 00000000/00", dat(0), rd_fwd); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL r0_stall: got %b exp 0", stall_o); end
    endtask

    task automatic test_flush_stall();
        clear_pipe();
        issue(5'd3, 2'd0);
        set_rd(0, 5'd3, 2'd0, 32'h33);
        set_stg(32'h300, 32'h301, 32'h302);
        #1;
        checks++; if (rd_fwd[0] !== 1'b1) begin errors++; $display("FAIL fl_pre: got %b exp 1", rd_fwd[0]); end
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        #1;
        checks++; if (rd_fwd[0] !== 1'b0 || dat(0) !== 32'h33) begin errors++; $display("FAIL fl_clear: got %h/%b exp 00000033/0", dat(0), rd_fwd[0]); end
        // Flush wins over a simultaneous issue.
        clear_rd();
        flush_i = 1'b1;
        iss_valid = 1'b1; iss_we = 1'b1; iss_waddr = 5'd4; iss_tnew = 2'd0;
        cyc();
        flush_i = 1'b0; iss_valid = 1'b0; iss_we = 1'b0;
        set_rd(0, 5'd4, 2'd0, 32'h44);
        #1;
        checks++; if (rd_fwd[0] !== 1'b0 || dat(0) !== 32'h44) begin errors++; $display("FAIL fl_vs_issue: got %h/%b exp 00000044/0", dat(0), rd_fwd[0]); end
        // stall_i blocks the new issue but older producers still advance.
        clear_pipe();
        issue(5'd11, 2'd0);
        stall_i = 1'b1;
        iss_valid = 1'b1; iss_we = 1'b1; iss_waddr = 5'd10; iss_tnew = 2'd0;
        cyc();
        stall_i = 1'b0; iss_valid = 1'b0; iss_we = 1'b0;
        set_stg(32'h1, 32'h2, 32'h3);
        set_rd(0, 5'd11, 2'd0, 32'hB0);
        set_rd(1, 5'd10, 2'd0, 32'hA0);
        #1;
        checks++; if (rd_fwd[0] !== 1'b1 || dat(0) !== 32'h2) begin errors++; $display("FAIL sti_shift: got %h/%b exp 00000002/1", dat(0), rd_fwd[0]); end
        checks++; if (rd_fwd[1] !== 1'b0 || dat(1) !== 32'hA0) begin errors++; $display("FAIL sti_bubble: got %h/%b exp 000000a0/0", dat(1), rd_fwd[1]); end
        // Asynchronous reset clears tracked producers without a clock edge.
        clear_pipe();
        issue(5'd13, 2'd0);
        set_rd(0, 5'd13, 2'd0, 32'hD0);
        set_rd(1, 5'd0, 2'd0, 32'h0);
        set_stg(32'h13, 32'h0, 32'h0);
        #1;
        checks++; if (rd_fwd[0] !== 1'b1) begin errors++; $display("FAIL arst_pre: got %b exp 1", rd_fwd[0]); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (rd_fwd[0] !== 1'b0 || dat(0) !== 32'hD0) begin errors++; $display("FAIL arst_clear: got %h/%b exp 000000d0/0", dat(0), rd_fwd[0]); end
        cyc();
        reset_n = 1'b1;
        issue(5'd14, 2'd0);
        set_rd(0, 5'd14, 2'd0, 32'hE0);
        set_stg(32'h14, 32'h0, 32'h0);
        #1;
        checks++; if (rd_fwd[0] !== 1'b1 || dat(0) !== 32'h14) begin errors++; $display("FAIL arst_release: got %h/%b exp 00000014/1", dat(0), rd_fwd[0]); end
    endtask

`ifdef FWD_TRACKER_STAT_EN
    task automatic test_stats();
        clear_pipe();
        checks++; if (stat_stall !== 32'd0 || stat_fwd !== 32'd0) begin errors++; $display("FAIL stat_flush: got %0d/%0d exp 0/0", stat_stall, stat_fwd); end
        issue(5'd9, 2'd3);
        set_rd(1, 5'd9, 2'd0, 32'h0);
        cyc(); cyc(); cyc();
        clear_rd();
        issue(5'd8, 2'd0);
        set_rd(0, 5'd8, 2'd0, 32'h0);
        cyc(); cyc();
        clear_rd();
        cyc();
        checks++; if (stat_stall !== 32'd3) begin errors++; $display("FAIL stat_stall: got %0d exp 3", stat_stall); end
        checks++; if (stat_fwd !== 32'd2) begin errors++; $display("FAIL stat_fwd: got %0d exp 2", stat_fwd); end
        issue(5'd9, 2'd1);
        dut.stat_stall_q = 32'hFFFF_FFFF;
        set_rd(1, 5'd9, 2'd0, 32'h0);
        cyc();
        clear_rd();
        checks++; if (stat_stall !== 32'd0) begin errors++; $display("FAIL stat_wrap: got %h exp 00000000", stat_stall); end
    endtask
`endif

    initial begin
        reset_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        iss_valid = 1'b0; iss_we = 1'b0; iss_waddr = '0; iss_tnew = '0;
        stg_data = '0; rd_addr = '0; rd_tuse = '0; rf_data = '0;
        #2;
        test_reset();
        test_fwd_e();
        test_load_use();
        test_priority();
        test_reg_zero();
        test_flush_stall();
`ifdef FWD_TRACKER_STAT_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
